apb_cmd_regbank: RTL and testbench

//  Parametrised APB slave register bank with a command register, configurable wait states and

---
 rtl/apb_cmd_regbank_if.sv | 34 +++
 rtl/apb_cmd_regbank.sv | 212 +++++++++++++++++++++
 tb/tb_apb_cmd_regbank.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_cmd_regbank_if.sv
// APB bus bundle for the audioport command register bank.
// Master drives the request side, slave returns ready/data/error.
interface apb_cmd_regbank_if;
  logic        psel_in;
  logic        penable_in;
  logic        pwrite_in;
  logic [31:0] paddr_in;
  logic [31:0] pwdata_in;
  logic [31:0] prdata_out;
  logic        pready_out;
  logic        pslverr_out;

  modport master (
    output psel_in,
    output penable_in,
    output pwrite_in,
    output paddr_in,
    output pwdata_in,
    input  prdata_out,
    input  pready_out,
    input  pslverr_out
  );

  modport slave (
    input  psel_in,
    input  penable_in,
    input  pwrite_in,
    input  paddr_in,
    input  pwdata_in,
    output prdata_out,
    output pready_out,
    output pslverr_out
  );
endinterface

// File: rtl/apb_cmd_regbank.sv
// APB register bank with command decode, play state and
// programmable wait states for command writes and reads.
module apb_cmd_regbank #(
  parameter int NUM_REGS = 8,
  parameter int CMD_IDX  = 0,
  parameter int ADDR_LSB = 2,
  parameter int CMD_WAIT = 4,
  parameter int RD_WAIT  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  apb_cmd_regbank_if.slave       apb,
  output logic [NUM_REGS*32-1:0] regs_out,
  output logic                   start_out,
  output logic                   stop_out,
  output logic                   clr_out,
  output logic                   cfg_out,
  output logic                   level_out,
  output logic                   play_out,
  output logic                   busy_out
);

  localparam int IW = $clog2(NUM_REGS);
  localparam logic [31:0] LSB_MASK =
    (32'd1 << ADDR_LSB) - 32'd1;
  localparam logic [31:0] NREGS = 32'(NUM_REGS);
  localparam logic [IW-1:0] CIDX = IW'(CMD_IDX);
  localparam logic [7:0] CW = 8'(CMD_WAIT);
  localparam logic [7:0] RW = 8'(RD_WAIT);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_d;
  logic        is_cmd_q;
  logic        is_cmd_d;
  logic [31:0] regs_q [NUM_REGS];
  logic        play_q;
  logic        start_q;
  logic        stop_q;
  logic        clr_q;
  logic        cfg_q;
  logic        level_q;

  logic [31:0] word;
  logic [IW-1:0] idx;
  logic        addr_err;
  logic        hit_cmd;
  logic        cmd_wr;
  logic        c_start;
  logic        c_stop;
  logic        c_clr;
  logic        c_cfg;
  logic        c_level;
  logic        code_ok;
  logic        cmd_err;
  logic        setup;
  logic        access;
  logic        done;
  logic        cmd_go;
  logic        reg_wr;
  logic [7:0]  waits;

  assign word = apb.paddr_in >> ADDR_LSB;
  assign idx  = word[IW-1:0];

  assign addr_err = (word >= NREGS) ||
    ((apb.paddr_in & LSB_MASK) != 32'd0);

  assign hit_cmd = !addr_err && (idx == CIDX);
  assign cmd_wr  = hit_cmd && apb.pwrite_in;

  assign c_start = apb.pwdata_in == 32'd1;
  assign c_stop  = apb.pwdata_in == 32'd2;
  assign c_clr   = apb.pwdata_in == 32'd3;
  assign c_cfg   = apb.pwdata_in == 32'd4;
  assign c_level = apb.pwdata_in == 32'd5;

  // CLR and CFG are only legal while stopped
  assign code_ok = c_start | c_stop | c_level |
    ((c_clr | c_cfg) & !play_q);
  assign cmd_err = cmd_wr & !code_ok;

  assign setup  = apb.psel_in & !apb.penable_in;
  assign access = apb.psel_in & apb.penable_in;
  assign done   = access & apb.pready_out;
  assign cmd_go = done & cmd_wr & code_ok;
  assign reg_wr = done & apb.pwrite_in &
    !addr_err & !hit_cmd;

  always_comb begin
    waits = 8'd0;
    unique case (1'b1)
      addr_err:
        waits = 8'd0;
      cmd_wr:
        waits = CW;
      !addr_err && !apb.pwrite_in:
        waits = RW;
      !addr_err && apb.pwrite_in && !hit_cmd:
        waits = 8'd0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_cmd_d = is_cmd_q;
    unique case (state_q)
      IDLE: begin
        if (setup && waits != 8'd0) begin
          state_d  = WAIT;
          cnt_d    = waits;
          is_cmd_d = cmd_wr;
        end
      end
      WAIT: begin
        if (!apb.psel_in) begin
          state_d  = IDLE;
          cnt_d    = 8'd0;
          is_cmd_d = 1'b0;
        end else if (apb.penable_in) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d  = DONE;
            is_cmd_d = 1'b0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = 8'd0;
        is_cmd_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      is_cmd_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_cmd_q <= is_cmd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= 32'd0;
      play_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      clr_q   <= 1'b0;
      cfg_q   <= 1'b0;
      level_q <= 1'b0;
    end else begin
      start_q <= cmd_go & c_start;
      stop_q  <= cmd_go & c_stop;
      clr_q   <= cmd_go & c_clr;
      cfg_q   <= cmd_go & c_cfg;
      level_q <= cmd_go & c_level;
      if (reg_wr)
        regs_q[idx] <= apb.pwdata_in;
      if (cmd_go)
        regs_q[CIDX] <= apb.pwdata_in;
      if (cmd_go && c_start)
        play_q <= 1'b1;
      else if (cmd_go && c_stop)
        play_q <= 1'b0;
    end
  end

  assign busy_out  = (state_q == WAIT) && is_cmd_q;
  assign play_out  = play_q;
  assign start_out = start_q;
  assign stop_out  = stop_q;
  assign clr_out   = clr_q;
  assign cfg_out   = cfg_q;
  assign level_out = level_q;

  assign apb.pready_out  = state_q != WAIT;
  assign apb.pslverr_out = done & (addr_err | cmd_err);

  // status word replaces the stored code on reads
  always_comb begin
    apb.prdata_out = 32'd0;
    if (done && !apb.pwrite_in && !addr_err) begin
      if (hit_cmd)
        apb.prdata_out = {30'd0, busy_out, play_q};
      else
        apb.prdata_out = regs_q[idx];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign regs_out[g*32 +: 32] = regs_q[g];
  end

endmodule

// File: tb/tb_apb_cmd_regbank.sv
// Directed bench for apb_cmd_regbank: default instance plus a
// second one with two read wait states sharing the same bus drive.
module tb_apb_cmd_regbank;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = 32'd0;
  logic [31:0] pwdata = 32'd0;

  logic [255:0] regs0;
  logic [255:0] regs1;
  logic start0, stop0, clr0, cfg0, level0, play0, busy0;
  logic start1, stop1, clr1, cfg1, level1, play1, busy1;
  logic [4:0] pulses0;

  apb_cmd_regbank_if b0 ();
  apb_cmd_regbank_if b1 ();

  assign b0.psel_in    = psel;
  assign b0.penable_in = penable;
  assign b0.pwrite_in  = pwrite;
  assign b0.paddr_in   = paddr;
  assign b0.pwdata_in  = pwdata;
  assign b1.psel_in    = psel;
  assign b1.penable_in = penable;
  assign b1.pwrite_in  = pwrite;
  assign b1.paddr_in   = paddr;
  assign b1.pwdata_in  = pwdata;

  assign pulses0 = {start0, stop0, clr0, cfg0, level0};

  apb_cmd_regbank u0 (
    .clk       (clk),
    .rst       (rst),
    .apb       (b0.slave),
    .regs_out  (regs0),
    .start_out (start0),
    .stop_out  (stop0),
    .clr_out   (clr0),
    .cfg_out   (cfg0),
    .level_out (level0),
    .play_out  (play0),
    .busy_out  (busy0)
  );

  apb_cmd_regbank #(.RD_WAIT(2)) u1 (
    .clk       (clk),
    .rst       (rst),
    .apb       (b1.slave),
    .regs_out  (regs1),
    .start_out (start1),
    .stop_out  (stop1),
    .clr_out   (clr1),
    .cfg_out   (cfg1),
    .level_out (level1),
    .play_out  (play1),
    .busy_out  (busy1)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] rd_v;
  logic        er_v;
  int          nw_v;
  int          nb_v;
  logic [4:0]  pl_v;
  logic [4:0]  pl2_v;
  logic        play_v;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic rdy(input bit s1);
    return s1 ? b1.pready_out : b0.pready_out;
  endfunction

  task automatic xfer(input logic wr,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input bit s1);
    int guard;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    #1;
    nw_v = 0; nb_v = 0; guard = 0;
    while (!rdy(s1) && guard < 20) begin
      nw_v++;
      if (s1 ? busy1 : busy0) nb_v++;
      @(posedge clk); #2;
      guard++;
    end
    if (guard >= 20) check("timeout", 32'(guard), 32'd0);
    rd_v = s1 ? b1.prdata_out : b0.prdata_out;
    er_v = s1 ? b1.pslverr_out : b0.pslverr_out;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    #1;
    pl_v = pulses0;
    play_v = play0;
    @(posedge clk); #2;
    pl2_v = pulses0;
  endtask

  initial begin
    int cnt;
    repeat (2) @(posedge clk);
    #2;
    check("rst_pready", 32'(b0.pready_out), 32'd1);
    check("rst_err", 32'(b0.pslverr_out), 32'd0);
    check("rst_rdata", b0.prdata_out, 32'd0);
    check("rst_regs", 32'(|regs0), 32'd0);
    check("rst_misc", {25'd0, pulses0, play0, busy0}, 32'd0);
    rst = 1'b0;

    // plain zero-wait register write
    xfer(1'b1, 32'h8, 32'hA5, 1'b0);
    check("t1_waits", 32'(nw_v), 32'd0);
    check("t1_err", 32'(er_v), 32'd0);
    check("t1_reg2", regs0[95:64], 32'hA5);

    // START with four wait states
    xfer(1'b1, 32'h0, 32'd1, 1'b0);
    check("t2_waits", 32'(nw_v), 32'd4);
    check("t2_busy", 32'(nb_v), 32'd4);
    check("t2_err", 32'(er_v), 32'd0);
    check("t2_pulse", 32'(pl_v), 32'b10000);
    check("t2_pulse1cyc", 32'(pl2_v), 32'd0);
    check("t2_play", 32'(play_v), 32'd1);
    xfer(1'b0, 32'h0, 32'd0, 1'b0);
    check("t2_rdcmd", rd_v, 32'h1);

    // CLR while playing is refused
    xfer(1'b1, 32'h0, 32'd3, 1'b0);
    check("t3_waits", 32'(nw_v), 32'd4);
    check("t3_err", 32'(er_v), 32'd1);
    check("t3_nopulse", 32'(pl_v), 32'd0);
    check("t3_cmdreg", regs0[31:0], 32'd1);
    xfer(1'b1, 32'h0, 32'd2, 1'b0);
    check("t3_stop_err", 32'(er_v), 32'd0);
    check("t3_stop", 32'(pl_v), 32'b01000);
    check("t3_play", 32'(play_v), 32'd0);
    xfer(1'b1, 32'h0, 32'd4, 1'b0);
    check("t3_cfg", 32'(pl_v), 32'b00010);
    check("t3_cfg_err", 32'(er_v), 32'd0);
    xfer(1'b1, 32'h0, 32'd5, 1'b0);
    check("t3_level", 32'(pl_v), 32'b00001);
    xfer(1'b1, 32'h0, 32'd7, 1'b0);
    check("t3_bad_err", 32'(er_v), 32'd1);
    check("t3_bad_pulse", 32'(pl_v), 32'd0);
    check("t3_bad_reg", regs0[31:0], 32'd5);

    // address errors
    xfer(1'b0, 32'h20, 32'd0, 1'b0);
    check("t4_rd_err", 32'(er_v), 32'd1);
    check("t4_rd_data", rd_v, 32'd0);
    check("t4_rd_waits", 32'(nw_v), 32'd0);
    xfer(1'b1, 32'h6, 32'h77, 1'b0);
    check("t4_wr_err", 32'(er_v), 32'd1);
    check("t4_wr_waits", 32'(nw_v), 32'd0);
    check("t4_reg1", regs0[63:32], 32'd0);
    check("t4_reg2", regs0[95:64], 32'hA5);

    // abort a START after two wait cycles
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0;
    pwrite = 1'b1; paddr = 32'h0; pwdata = 32'd1;
    @(posedge clk); #1;
    penable = 1'b1;
    #1;
    check("t5_w1", 32'(b0.pready_out), 32'd0);
    @(posedge clk); #2;
    check("t5_w2", 32'(b0.pready_out), 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #2;
    check("t5_idle", {30'd0, b0.pready_out, busy0}, 32'b10);
    cnt = 0;
    repeat (6) begin
      if (start0) cnt++;
      @(posedge clk); #2;
    end
    check("t5_nostart", 32'(cnt), 32'd0);
    check("t5_play", 32'(play0), 32'd0);

    // reset during a LEVEL command while playing
    xfer(1'b1, 32'h0, 32'd1, 1'b0);
    check("t5_replay", 32'(play_v), 32'd1);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0;
    pwrite = 1'b1; paddr = 32'h0; pwdata = 32'd5;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #2;
    check("t5_busy", 32'(busy0), 32'd1);
    rst = 1'b1;
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #2;
    check("t5_rst_pready", 32'(b0.pready_out), 32'd1);
    check("t5_rst_misc", {25'd0, pulses0, play0, busy0}, 32'd0);
    check("t5_rst_regs", 32'(|regs0), 32'd0);
    rst = 1'b0;
    cnt = 0;
    repeat (4) begin
      @(posedge clk); #2;
      if (level0) cnt++;
    end
    check("t5_nolevel", 32'(cnt), 32'd0);

    // read wait states on the second instance
    xfer(1'b1, 32'h8, 32'hA5, 1'b0);
    check("t6_reg2", regs1[95:64], 32'hA5);
    xfer(1'b0, 32'h8, 32'd0, 1'b1);
    check("t6_waits", 32'(nw_v), 32'd2);
    check("t6_data", rd_v, 32'hA5);
    check("t6_err", 32'(er_v), 32'd0);
    xfer(1'b0, 32'h8, 32'd0, 1'b0);
    check("t6_rd0_waits", 32'(nw_v), 32'd0);
    check("t6_rd0_data", rd_v, 32'hA5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
